ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched RS/RT operand values plus a decoded mul/div op, and computes MULT/MULTU/DIV/DIVU over 32 iterations.
- Holds results in architectural HI/LO registers.
- Raises a stall so the hazard logic freezes PC, IF/ID and ID/EX until the result is ready.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  the EX-stage instruction is a mul/div op
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- flush_i  in  1  abort any in-flight op
- rs_i  in  WIDTH  operand A (multiplicand / dividend), from ID/EX RS output
- rt_i  in  WIDTH  operand B (multiplier / divisor), from ID/EX RT output
- hi_o  out  WIDTH  HI register (product high word / remainder)
- lo_o  out  WIDTH  LO register (product low word / quotient)
- busy_o  out  1  high in RUN and FIX
- done_o  out  1  one-cycle pulse when HI/LO have just been updated
- stall_o  out  1  pipeline freeze request to the hazard unit

Behaviour:
- Interface: one clock (clk_i). Reset rst_i is synchronous and active-high.
- Reset:
  - state=IDLE; hi_o=lo_o=0; done_o=0; busy_o=0; internal counters and accumulators cleared.
  - Reset overrides every other input, including mid-operation.
- States:
  - IDLE: start_i=1 and flush_i=0 → latch op_i, latch operand magnitudes (signed ops take abs value), record the sign flags, counter=0 → RUN.
  - RUN: one iteration per cycle.
    - Multiply: shift-add on a 64-bit accumulator.
    - Divide: restoring shift-subtract (remainder and quotient registers).
    - Counter increments each cycle; counter==ITER-1 → FIX.
  - FIX: apply sign correction and write hi_o/lo_o → DONE.
  - DONE: done_o=1 for this cycle only; start_i is ignored → IDLE.
- Latency: start sampled at edge k; iterations on edges k+1..k+32; HI/LO written at edge k+33; done_o high in the cycle after edge k+33.
- Stall:
  - stall_o = (IDLE and start_i and !flush_i) or RUN or FIX.
  - stall_o is 0 in DONE, so the mul/div instruction leaves EX at the end of the DONE cycle.
  - The next start_i seen in IDLE therefore always belongs to a new instruction.
- Sign rules:
  - MULT: 64-bit product negated if the operand signs differ.
  - DIV: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Unsigned ops: no correction.
- Boundary cases:
  - Divide by zero (DIV or DIVU): LO=all ones, HI=rs_i as latched (original signed value); no sign fix; normal latency.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (two's-complement wrap; no trap).
  - MULT 0x80000000 * 0x80000000: HI=0x40000000, LO=0.
- flush_i:
  - In RUN or FIX: → IDLE next edge; hi_o/lo_o unchanged; no done_o.
  - In IDLE: start_i is ignored.
  - In DONE: no effect (HI/LO were already written).
- HI/LO change only at the FIX→DONE edge or on reset.

Decomposition:
- Shared package holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state encoding IDLE/RUN/FIX/DONE (2 bits);
  - WIDTH/ITER constants.
- One natural sub-module: muldiv_step, the combinational single-iteration datapath.
  - Inputs: accumulator, remainder, quotient, operand, op class.
  - Outputs: next accumulator, remainder and quotient.
- FSM, counter, sign fix and HI/LO registers stay in ex_muldiv.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; done_o exactly 34 cycles after start is sampled; stall_o high for 34 cycles then low in the DONE cycle.
- MULT rs=0xFFFFFFFD (-3), rt=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy_o deasserted in DONE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=100, rt=7 → LO=14, HI=2.
- DIVU rs=7, rt=0 → LO=0xFFFFFFFF, HI=7; DIV rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- HI/LO preloaded via a prior MULTU 3*4 (HI=0, LO=12); start a DIV and assert flush_i at RUN iteration 10 → IDLE next cycle, stall_o=0, no done_o, HI=0 and LO=12 unchanged.
- rst_i asserted mid-RUN → next cycle state IDLE, hi_o=lo_o=0, stall_o=0; back-to-back MULTU ops with start_i held → two done_o pulses, second result correct.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - MD_WIDTH / MD_ITER : default operand width and iteration count
//   - op_e               : decoded mul/div operation (MULT, MULTU, DIV, DIVU)
//   - state_e            : sequencer states (IDLE, RUN, FIX, DONE)
//   - op_is_div / op_is_signed : helpers that classify an op_e value
package ex_muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Upper op bit selects divide, lower op bit selects unsigned.
  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// ex_muldiv_step: combinational datapath for one mul/div iteration.
//   acc_i     : 2*WIDTH multiply accumulator {partial high, remaining multiplier}
//   rem_i     : divide partial remainder
//   quot_i    : divide quotient register (unconsumed dividend bits shift out at the top)
//   operand_i : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   is_div_i  : 1 = divide iteration, 0 = multiply iteration
//   acc_o / rem_o / quot_o : register values after this iteration
// Registers that do not belong to the selected op class pass through unchanged.
module ex_muldiv_step
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   rem_i,
  input  logic [WIDTH-1:0]   quot_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0]   rem_o,
  output logic [WIDTH-1:0]   quot_o
);

  // Multiply: add the multiplicand into the high half when the current
  // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
  // The extra sum bit keeps the carry, which becomes the new top bit.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_acc_next;

  assign mul_sum      = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                      + (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
  assign mul_acc_next = {mul_sum, acc_i[WIDTH-1:1]};

  // Restoring divide: bring the next dividend bit into the remainder and try
  // subtracting the divisor; a non-negative difference sets the quotient bit.
  // The partial remainder is always below the divisor, so the shifted value
  // fits WIDTH+1 bits and a successful difference fits WIDTH bits.
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_ok;

  assign div_shift = {rem_i, quot_i[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, operand_i};
  assign div_ok    = ~div_diff[WIDTH];

  always_comb begin
    acc_o  = acc_i;
    rem_o  = rem_i;
    quot_o = quot_i;
    if (is_div_i) begin
      rem_o  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], div_ok};
    end else begin
      acc_o  = mul_acc_next;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit in the EX stage.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   start_i : EX-stage instruction is a mul/div op
//   op_i    : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   flush_i : abort any in-flight op
//   rs_i    : operand A (multiplicand / dividend)
//   rt_i    : operand B (multiplier / divisor)
//   hi_o    : HI register (product high word / remainder)
//   lo_o    : LO register (product low word / quotient)
//   busy_o  : high in RUN and FIX
//   done_o  : one-cycle pulse after HI/LO are written
//   stall_o : pipeline freeze request to the hazard unit
// Operation runs on unsigned magnitudes for ITER cycles; the sign
// correction and HI/LO write happen in the single FIX cycle.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  state_e             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  op_e                op_reg;
  logic [WIDTH-1:0]   a_mag_reg, b_mag_reg, rs_raw_reg;
  logic               neg_a_reg, neg_b_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   rem_reg, quot_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic [WIDTH-1:0]   hi_next, lo_next;

  logic               accept;
  logic               in_signed;
  logic               is_div;
  logic [WIDTH-1:0]   rs_abs, rt_abs;

  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   rem_step, quot_step;
  logic [2*WIDTH-1:0] prod_fix;

  assign accept    = (state_reg == IDLE) && start_i && !flush_i;
  assign in_signed = op_is_signed(op_e'(op_i));
  assign is_div    = op_is_div(op_reg);

  // Signed ops run on magnitudes; 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude 2^31.
  assign rs_abs = (in_signed && rs_i[WIDTH-1]) ? -rs_i : rs_i;
  assign rt_abs = (in_signed && rt_i[WIDTH-1]) ? -rt_i : rt_i;

  ex_muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i     (acc_reg),
    .rem_i     (rem_reg),
    .quot_i    (quot_reg),
    .operand_i (is_div ? b_mag_reg : a_mag_reg),
    .is_div_i  (is_div),
    .acc_o     (acc_step),
    .rem_o     (rem_step),
    .quot_o    (quot_step)
  );

  // ---------------- next-state and status outputs ----------------
  always_comb begin
    state_next = state_reg;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    stall_o    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
          stall_o    = 1'b1;
        end
      end
      RUN: begin
        busy_o  = 1'b1;
        stall_o = 1'b1;
        if (flush_i) begin
          state_next = IDLE;
        end else if (cnt_reg == CW'(ITER - 1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        busy_o     = 1'b1;
        stall_o    = 1'b1;
        state_next = flush_i ? IDLE : DONE;
      end
      DONE: begin
        // Stall drops here so the mul/div instruction leaves EX this cycle.
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- sign correction ----------------
  assign prod_fix = (neg_a_reg ^ neg_b_reg) ? -acc_reg : acc_reg;

  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (!is_div) begin
      hi_next = prod_fix[2*WIDTH-1:WIDTH];
      lo_next = prod_fix[WIDTH-1:0];
    end else if (b_mag_reg == '0) begin
      // Divide by zero: quotient all ones, remainder is the untouched dividend.
      hi_next = rs_raw_reg;
      lo_next = '1;
    end else begin
      lo_next = (neg_a_reg ^ neg_b_reg) ? -quot_reg : quot_reg;
      hi_next = neg_a_reg ? -rem_reg : rem_reg;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= OP_MULT;
      a_mag_reg  <= '0;
      b_mag_reg  <= '0;
      rs_raw_reg <= '0;
      neg_a_reg  <= 1'b0;
      neg_b_reg  <= 1'b0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      quot_reg   <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      state_reg <= state_next;
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg     <= op_e'(op_i);
            a_mag_reg  <= rs_abs;
            b_mag_reg  <= rt_abs;
            rs_raw_reg <= rs_i;
            neg_a_reg  <= in_signed & rs_i[WIDTH-1];
            neg_b_reg  <= in_signed & rt_i[WIDTH-1];
            cnt_reg    <= '0;
            // Multiplier sits in the low half and is consumed LSB first;
            // the dividend is consumed MSB first out of the quotient register.
            acc_reg    <= {{WIDTH{1'b0}}, rt_abs};
            rem_reg    <= '0;
            quot_reg   <= rs_abs;
          end
        end
        RUN: begin
          acc_reg  <= acc_step;
          rem_reg  <= rem_step;
          quot_reg <= quot_step;
          cnt_reg  <= cnt_reg + 1'b1;
        end
        FIX: begin
          if (!flush_i) begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o = hi_reg;
  assign lo_o = lo_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, randomized ops
// against an arithmetic reference, and hand-written flush/reset/back-to-back
// sequences.
module tb_ex_muldiv;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic        flush_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        done_o;
  logic        stall_o;

  int checks   = 0;
  int failures = 0;

  ex_muldiv #(.WIDTH(32), .ITER(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .flush_i (flush_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .stall_o (stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural definitions. Returns {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    res = '0;
    case (op)
      2'b00: begin
        q = sa * sb;
        res = q;
      end
      2'b01: res = ua * ub;
      2'b10: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else res = {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Runs one op starting just after a rising edge; returns just after the
  // DONE->IDLE edge. With timing set it also checks latency and stall/busy.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit timing, output logic [31:0] hi, output logic [31:0] lo);
    int  n;
    bit  got;
    int  bad_stall;
    start_i = 1'b1;
    op_i    = op;
    rs_i    = a;
    rt_i    = b;
    @(negedge clk_i);
    if (timing) chk("stall_at_start", {63'h0, stall_o}, 64'h1);
    @(posedge clk_i);
    #1;
    start_i   = 1'b0;
    n         = 0;
    got       = 1'b0;
    bad_stall = 0;
    while (n < 100 && !got) begin
      @(negedge clk_i);
      n++;
      if (done_o) got = 1'b1;
      else if (!stall_o || !busy_o) bad_stall++;
    end
    hi = hi_o;
    lo = lo_o;
    if (!got) chk("done_timeout", 64'h0, 64'h1);
    if (timing) begin
      chk("done_latency", 64'(n), 64'd34);
      chk("stall_busy_while_running", 64'(bad_stall), 64'd0);
      chk("stall_in_done", {63'h0, stall_o}, 64'h0);
      chk("busy_in_done", {63'h0, busy_o}, 64'h0);
    end
    @(posedge clk_i);
    #1;
    if (timing) chk("done_one_cycle", {63'h0, done_o}, 64'h0);
    $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h cycles=%0d", op, a, b, hi, lo, n);
  endtask

  initial begin
    logic [31:0] hi, lo, a, b;
    logic [63:0] exp;
    logic [1:0]  op;
    int          dn, cyc, first_done, extra;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4]  = '{2'b11, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9]  = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[10] = '{2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    vecs[11] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

    rst_i   = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = 2'b00;
    rs_i    = '0;
    rt_i    = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_hi", {32'h0, hi_o}, 64'h0);
    chk("reset_lo", {32'h0, lo_o}, 64'h0);
    chk("reset_busy", {63'h0, busy_o}, 64'h0);
    chk("reset_done", {63'h0, done_o}, 64'h0);
    chk("reset_stall", {63'h0, stall_o}, 64'h0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i < 2), hi, lo);
      chk($sformatf("vec%0d_hi", i), {32'h0, hi}, {32'h0, vecs[i].hi});
      chk($sformatf("vec%0d_lo", i), {32'h0, lo}, {32'h0, vecs[i].lo});
    end

    // Randomized ops against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = pick_operand();
      b   = pick_operand();
      exp = ref_model(op, a, b);
      run_op(op, a, b, 1'b0, hi, lo);
      chk($sformatf("rand%0d_hilo", i), {hi, lo}, exp);
    end

    // Flush mid-RUN leaves previously written HI/LO alone.
    run_op(2'b01, 32'd3, 32'd4, 1'b0, hi, lo);
    chk("preload_hilo", {hi, lo}, 64'h0000_0000_0000_000C);
    start_i = 1'b1;
    op_i    = 2'b10;
    rs_i    = 32'd1000;
    rt_i    = 32'd3;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    chk("flush_stall", {63'h0, stall_o}, 64'h0);
    chk("flush_busy", {63'h0, busy_o}, 64'h0);
    chk("flush_done", {63'h0, done_o}, 64'h0);
    dn = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) dn++;
    end
    chk("flush_no_done", 64'(dn), 64'd0);
    chk("flush_hilo_kept", {hi_o, lo_o}, 64'h0000_0000_0000_000C);
    $display("flush in RUN: hi=%h lo=%h done_pulses=%0d", hi_o, lo_o, dn);

    // Flush in IDLE masks start.
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("idle_flush_stall", {63'h0, stall_o}, 64'h0);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("idle_flush_busy", {63'h0, busy_o}, 64'h0);
    $display("flush in IDLE: busy=%0d", busy_o);

    // Reset mid-RUN.
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, hi, lo);
    start_i = 1'b1;
    op_i    = 2'b01;
    rs_i    = 32'd9;
    rt_i    = 32'd9;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("midrst_hi", {32'h0, hi_o}, 64'h0);
    chk("midrst_lo", {32'h0, lo_o}, 64'h0);
    chk("midrst_stall", {63'h0, stall_o}, 64'h0);
    chk("midrst_busy", {63'h0, busy_o}, 64'h0);
    dn = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) dn++;
    end
    chk("midrst_no_done", 64'(dn), 64'd0);
    $display("reset mid-RUN: hi=%h lo=%h done_pulses=%0d", hi_o, lo_o, dn);

    // Back-to-back MULTU with start_i held high.
    @(posedge clk_i);
    #1;
    start_i    = 1'b1;
    op_i       = 2'b01;
    rs_i       = 32'd6;
    rt_i       = 32'd7;
    dn         = 0;
    cyc        = 0;
    first_done = 0;
    while (dn < 2 && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      if (done_o) begin
        dn++;
        if (dn == 1) begin
          first_done = cyc;
          chk("b2b_first_hilo", {hi_o, lo_o}, 64'd42);
          rs_i = 32'h1234_5678;
          rt_i = 32'h9ABC_DEF0;
        end else begin
          start_i = 1'b0;
          chk("b2b_gap", 64'(cyc - first_done), 64'd35);
          chk("b2b_second_hilo", {hi_o, lo_o},
              ref_model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));
        end
      end
    end
    start_i = 1'b0;
    chk("b2b_two_pulses", 64'(dn), 64'd2);
    $display("back-to-back: pulses=%0d hi=%h lo=%h", dn, hi_o, lo_o);
    extra = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) extra++;
    end
    chk("b2b_no_third", 64'(extra), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
